// File: rtl/rf_wb_if.sv
// Writeback bus between the two requesters (ALU, load) and the arbiter, plus
// the register-file write port and the RAW pending vector.
//   alu_valid/ready/addr/data : ALU writeback request handshake
//   ld_valid/ready/addr/data  : load writeback request handshake
//   wr_en/wr_addr/wr_data     : registered write into Reg_File
//   pending                   : bit r set while a write to register r is in flight
// master = requester/consumer side, slave = arbiter side.
interface rf_wb_if #(parameter int W = 8);
    logic           alu_valid;
    logic           alu_ready;
    logic [2:0]     alu_addr;
    logic [W-1:0]   alu_data;
    logic           ld_valid;
    logic           ld_ready;
    logic [2:0]     ld_addr;
    logic [W-1:0]   ld_data;
    logic           wr_en;
    logic [2:0]     wr_addr;
    logic [W-1:0]   wr_data;
    logic [7:0]     pending;

    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        input  alu_ready, ld_ready, wr_en, wr_addr, wr_data, pending
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        output alu_ready, ld_ready, wr_en, wr_addr, wr_data, pending
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Two requesters (index 0 = ALU, 1 = load) each feed a small FIFO; a
// round-robin arbiter drains one head per cycle into registered
// wr_en/wr_addr/wr_data. A pending vector marks every register with a queued
// or issuing write so decode can stall on RAW hazards.
// Ports:
//   clk_i    : clock
//   reset_ni : asynchronous active-low reset
//   bus      : rf_wb_if.slave (request handshakes, write port, pending)

// Per-requester FIFO. Also reports which registers its live entries target.
module rf_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [2:0]    addr_i,
    input  logic [DW-1:0] data_i,
    output logic [2:0]    head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [7:0]    pend_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][2:0]    addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            rd_q, wr_q;
    logic [PW:0]              cnt_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: only slots inside [rd, rd+cnt) are read.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            addr_q[wr_q] <= addr_i;
            data_q[wr_q] <= data_i;
        end
    end

    assign head_addr_o = addr_q[rd_q];
    assign head_data_o = data_q[rd_q];
    assign full_o      = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o     = (cnt_q == '0);

    // Walk the live window starting at the read pointer; pointer add wraps
    // naturally because DEPTH is a power of two.
    always_comb begin
        pend_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW+1)'(k) < cnt_q)
                pend_o[addr_q[rd_q + PW'(k)]] = 1'b1;
        end
    end
endmodule

module rf_wb_arbiter #(
    parameter int NUM_DOMAINS = 1,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic    clk_i,
    input  logic    reset_ni,
    rf_wb_if.slave  bus
);
    localparam int W    = NUM_DOMAINS * 8;
    localparam int NREQ = 2;

    typedef enum logic {RR_ALU = 1'b0, RR_LD = 1'b1} rr_e;

    typedef struct packed {
        logic [2:0]   addr;
        logic [W-1:0] data;
    } wb_req_t;

    logic [NREQ-1:0]         push, full, empty, gnt;
    logic [NREQ-1:0][2:0]    in_addr, hd_addr;
    logic [NREQ-1:0][W-1:0]  in_data, hd_data;
    logic [NREQ-1:0][7:0]    pend;
    rr_e                     rr_q, rr_d;
    logic                    wr_en_q;
    wb_req_t                 wr_q, sel;
    logic [7:0]              pend_wr;

    // Ready comes from the registered count only, so a same-cycle pop never
    // opens a slot early.
    assign push    = {bus.ld_valid && !full[1], bus.alu_valid && !full[0]};
    assign in_addr = {bus.ld_addr, bus.alu_addr};
    assign in_data = {bus.ld_data, bus.alu_data};

    assign bus.alu_ready = !full[0];
    assign bus.ld_ready  = !full[1];

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        rf_wb_fifo #(.DEPTH(FIFO_DEPTH), .DW(W)) u_fifo (
            .clk_i       (clk_i),
            .reset_ni    (reset_ni),
            .push_i      (push[g]),
            .pop_i       (gnt[g]),
            .addr_i      (in_addr[g]),
            .data_i      (in_data[g]),
            .head_addr_o (hd_addr[g]),
            .head_data_o (hd_data[g]),
            .full_o      (full[g]),
            .empty_o     (empty[g]),
            .pend_o      (pend[g])
        );
    end

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        rr_d = rr_q;
        gnt  = '0;
        if (!empty[0] && (empty[1] || rr_q == RR_LD)) begin
            gnt[0] = 1'b1;
            rr_d   = RR_ALU;
        end else if (!empty[1]) begin
            gnt[1] = 1'b1;
            rr_d   = RR_LD;
        end
    end

    assign sel = gnt[1] ? wb_req_t'{hd_addr[1], hd_data[1]}
                        : wb_req_t'{hd_addr[0], hd_data[0]};

    // Address/data hold their last value when nothing is granted.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_q    <= RR_LD;
            wr_en_q <= 1'b0;
            wr_q    <= '0;
        end else begin
            rr_q    <= rr_d;
            wr_en_q <= |gnt;
            if (|gnt) wr_q <= sel;
        end
    end

    always_comb begin
        pend_wr = '0;
        if (wr_en_q) pend_wr[wr_q.addr] = 1'b1;
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_q.addr;
    assign bus.wr_data = wr_q.data;
    assign bus.pending = pend[0] | pend[1] | pend_wr;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    localparam int ND    = 2;
    localparam int DEPTH = 2;
    localparam int W     = ND * 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wb_if #(.W(W)) bus ();

    rf_wb_arbiter #(.NUM_DOMAINS(ND), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [2:0]   a;
        logic [W-1:0] d;
    } ent_t;

    // Reference model: one queue per requester, a scoreboard of expected writes.
    ent_t mq_a[$];
    ent_t mq_l[$];
    ent_t sb[$];
    bit   m_last_ld = 1'b1;
    bit   m_iss     = 1'b0;
    ent_t m_iss_e;
    bit   m_acc_a   = 1'b0;
    bit   m_acc_l   = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_pend();
        logic [7:0] p;
        p = '0;
        foreach (mq_a[i]) p[mq_a[i].a] = 1'b1;
        foreach (mq_l[i]) p[mq_l[i].a] = 1'b1;
        if (m_iss) p[m_iss_e.a] = 1'b1;
        return p;
    endfunction

    task automatic model_clear();
        mq_a.delete();
        mq_l.delete();
        sb.delete();
        m_last_ld = 1'b1;
        m_iss     = 1'b0;
        m_acc_a   = 1'b0;
        m_acc_l   = 1'b0;
    endtask

    // Model step: acceptance uses occupancy before the edge; grant alternates
    // when both have work, otherwise the single non-empty queue is served.
    always @(posedge clk) begin
        if (rst_n) begin
            m_acc_a = bus.alu_valid && (mq_a.size() < DEPTH);
            m_acc_l = bus.ld_valid  && (mq_l.size() < DEPTH);
            m_iss   = 1'b0;
            if (mq_a.size() > 0 && (mq_l.size() == 0 || m_last_ld)) begin
                m_iss_e   = mq_a.pop_front();
                m_iss     = 1'b1;
                m_last_ld = 1'b0;
            end else if (mq_l.size() > 0) begin
                m_iss_e   = mq_l.pop_front();
                m_iss     = 1'b1;
                m_last_ld = 1'b1;
            end
            if (m_iss) sb.push_back(m_iss_e);
            if (m_acc_a) mq_a.push_back('{bus.alu_addr, bus.alu_data});
            if (m_acc_l) mq_l.push_back('{bus.ld_addr, bus.ld_data});
        end
    end

    // Monitor: compares every output on the falling edge.
    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) begin
            chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
            chk("rst_pending", 32'(bus.pending), 32'd0);
            chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
            chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        end else begin
            chk("wr_en", 32'(bus.wr_en), 32'(m_iss));
            if (bus.wr_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(bus.wr_addr), 32'(e.a));
                    chk("wr_data", 32'(bus.wr_data), 32'(e.d));
                end
            end
            chk("alu_ready", 32'(bus.alu_ready), 32'(mq_a.size() < DEPTH));
            chk("ld_ready", 32'(bus.ld_ready), 32'(mq_l.size() < DEPTH));
            chk("pending", 32'(bus.pending), 32'(m_pend()));
        end
    end

    task automatic drive(input bit av, input logic [2:0] aa, input logic [W-1:0] ad,
                         input bit lv, input logic [2:0] la, input logic [W-1:0] ld);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_addr   = la;
        bus.ld_data   = ld;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        #12 rst_n = 1'b1;
        step(1);

        // Single ALU write, uncontended latency and pending window.
        drive(1, 3, 16'h005A, 0, 0, 0);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(5);

        // Both requesters every cycle: alternation, backpressure, held requests.
        drive(1, 1, 16'h1000, 1, 2, 16'h2000);
        for (int i = 1; i < 14; i++) begin
            step(1);
            if (m_acc_a) bus.alu_data = 16'h1000 + 16'(i);
            if (m_acc_l) bus.ld_data  = 16'h2000 + 16'(i);
        end
        drive(0, 0, 0, 0, 0, 0);
        step(8);

        // Two writes to r5: LD first, then ALU one cycle later.
        drive(0, 0, 0, 1, 5, 16'hAAAA);
        step(1);
        drive(1, 5, 16'h5555, 0, 0, 0);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(6);

        // Full-width data on the load path.
        drive(0, 0, 0, 1, 7, 16'hBEEF);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(4);

        // Random traffic; an unaccepted request is held unchanged.
        for (int i = 0; i < 300; i++) begin
            if (!bus.alu_valid || m_acc_a) begin
                bus.alu_valid = ($urandom_range(0, 9) < 6);
                bus.alu_addr  = 3'($urandom);
                bus.alu_data  = W'($urandom);
            end
            if (!bus.ld_valid || m_acc_l) begin
                bus.ld_valid = ($urandom_range(0, 9) < 5);
                bus.ld_addr  = 3'($urandom);
                bus.ld_data  = W'($urandom);
            end
            step(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        step(10);

        // Fill both FIFOs, then pulse reset asynchronously mid-cycle.
        drive(1, 4, 16'h4444, 1, 6, 16'h6666);
        step(5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_wr_en", 32'(bus.wr_en), 32'd0);
        chk("async_pending", 32'(bus.pending), 32'd0);
        chk("async_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("async_ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("async_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("async_wr_data", 32'(bus.wr_data), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        #12 rst_n = 1'b1;
        step(6);

        // A fresh push after reset still goes through.
        drive(1, 2, 16'h1234, 0, 0, 0);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(4);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("alu_model_empty", 32'(mq_a.size()), 32'd0);
        chk("ld_model_empty", 32'(mq_l.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
